// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the 8N1 UART receiver:
//               receiver state encoding, default frame geometry, counter
//               widths and the 2-of-3 majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int c_data_bits_def  = 8;
    localparam int c_oversample_def = 16;
    localparam int c_mid_sample_def = 7;

    localparam int c_tick_cnt_w = 4;
    localparam int c_bit_cnt_w  = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core_if
// Description : Host-side receive interface: received byte plus the one-cycle
//               ready and framing-error strobes. The receiver drives the
//               master modport; the host FIFO/consumer uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 rx_error;

    modport master (
        output rx_data,
        output rx_ready,
        output rx_error
    );

    modport slave (
        input rx_data,
        input rx_ready,
        input rx_error
    );
endinterface : uart_rx_core_if
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Front end of the UART receiver. Brings the asynchronous
//               serial line into the clock domain through two flops (reset to
//               the idle-high level) and turns the 16x baud reference into a
//               single-cycle tick on its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic baud_tick_16x,
    input  wire logic rx_serial,
    output logic      rx_sync,
    output logic      tick
);

    logic r_meta;
    logic r_sync;
    logic r_baud_d;

    // Two-flop synchronizer; reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rx_serial;
            r_sync <= r_meta;
        end
    end

    // Delayed copy of the baud reference for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_d <= 1'b0;
        end else begin
            r_baud_d <= baud_tick_16x;
        end
    end

    assign rx_sync = r_sync;
    assign tick    = baud_tick_16x & ~r_baud_d;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver with 16x oversampling and mid-bit sampling.
//               Publishes each correctly framed byte with a one-cycle ready
//               strobe and flags a low stop bit with a one-cycle error strobe.
//               Optional macro UART_RX_MAJORITY_EN: every sample becomes a
//               2-of-3 vote over three consecutive ticks, decided on the last.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = c_data_bits_def,
    parameter int OVERSAMPLE = c_oversample_def,
    parameter int MID_SAMPLE = c_mid_sample_def
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         baud_tick_16x,
    input  wire logic         rx_serial,
    uart_rx_core_if.master    rx_if
);

    localparam logic [c_tick_cnt_w-1:0] c_last_tick = c_tick_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_last_bit  = c_bit_cnt_w'(DATA_BITS - 1);

    logic                     w_rx_sync;
    logic                     w_tick;
    logic                     w_sample;

    rx_state_t                r_state;
    logic [c_tick_cnt_w-1:0]  r_tick_cnt;
    logic [c_bit_cnt_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0]     r_shift;
    logic [DATA_BITS-1:0]     r_data;
    logic                     r_ready;
    logic                     r_error;

    uart_rx_sync u_sync (
        .clk           (clk),
        .rst           (rst),
        .baud_tick_16x (baud_tick_16x),
        .rx_serial     (rx_serial),
        .rx_sync       (w_rx_sync),
        .tick          (w_tick)
    );

`ifdef UART_RX_MAJORITY_EN
    // Start decision moves one tick later so the vote window is centred on
    // MID_SAMPLE; data/stop keep the same offset from that decision point.
    localparam logic [c_tick_cnt_w-1:0] c_start_dec = c_tick_cnt_w'(MID_SAMPLE + 1);

    logic [1:0] r_hist;

    // Line history of the two previous ticks for the 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], w_rx_sync};
        end
    end

    assign w_sample = majority3(r_hist[1], r_hist[0], w_rx_sync);
`else
    localparam logic [c_tick_cnt_w-1:0] c_start_dec = c_tick_cnt_w'(MID_SAMPLE);

    assign w_sample = w_rx_sync;
`endif

    // Frame state machine with registered data and strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx_sync) begin
                            r_state    <= START;
                            r_tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (r_tick_cnt == c_start_dec) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            // A high line here was a glitch: drop back silently.
                            r_state    <= w_sample ? IDLE : DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (r_tick_cnt == c_last_tick) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_sample, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (r_tick_cnt == c_last_tick) begin
                            r_tick_cnt <= '0;
                            if (w_sample) begin
                                r_data  <= r_shift;
                                r_ready <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= WAIT_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    WAIT_IDLE: begin
                        // A break or stuck-low line must go high before re-arming.
                        if (w_rx_sync) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_if.rx_data  = r_data;
    assign rx_if.rx_ready = r_ready;
    assign rx_if.rx_error = r_error;

endmodule : uart_rx_core
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core. Stimulus pushes the
//               expected strobe (kind + byte) into a queue; a monitor pops
//               and compares whenever rx_ready or rx_error is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic baud_tick_16x;
    logic rx_serial;

    uart_rx_core_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_core #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .MID_SAMPLE (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick_16x (baud_tick_16x),
        .rx_serial     (rx_serial),
        .rx_if         (rx_if)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic [7:0] last_good;

    bit   pulse_mode = 1'b0;
    int   bcnt       = 0;
    logic baud_prev  = 1'b0;
    event e_tick;

    always #5 clk = ~clk;

    // Baud reference: square wave (4 high / 4 low) or 1-clk pulse every 4 clks.
    initial begin
        baud_tick_16x = 1'b0;
        forever begin
            @(negedge clk);
            if (pulse_mode) begin
                bcnt          = (bcnt + 1) % 4;
                baud_tick_16x = (bcnt == 0);
            end else begin
                bcnt          = (bcnt + 1) % 8;
                baud_tick_16x = (bcnt < 4);
            end
            if (baud_tick_16x && !baud_prev) -> e_tick;
            baud_prev = baud_tick_16x;
        end
    end

    // Scoreboard monitor: every strobe must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_if.rx_ready || rx_if.rx_error) begin
                n_tests++;
                if (rx_if.rx_ready && rx_if.rx_error) begin
                    n_fail++;
                    $display("FAIL both_strobes: ready=%b error=%b, required only one", rx_if.rx_ready, rx_if.rx_error);
                end else if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: ready=%b error=%b data=%02h, required no strobe",
                             rx_if.rx_ready, rx_if.rx_error, rx_if.rx_data);
                end else begin
                    e = sb_q.pop_front();
                    if (rx_if.rx_error !== e.is_err || rx_if.rx_data !== e.data) begin
                        n_fail++;
                        $display("FAIL strobe: got error=%b data=%02h, required error=%b data=%02h",
                                 rx_if.rx_error, rx_if.rx_data, e.is_err, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(e_tick);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        rx_serial = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            wait_ticks(16);
        end
        rx_serial = stop_v;
        wait_ticks(16);
    endtask

    task automatic expect_good(input logic [7:0] d);
        sb_q.push_back('{is_err: 1'b0, data: d});
        last_good = d;
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    initial begin
        logic [7:0] partial;
        rst       = 1'b1;
        rx_serial = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        check_val("reset_data",  rx_if.rx_data, 8'h00);
        check_val("reset_ready", {7'd0, rx_if.rx_ready}, 8'h00);
        check_val("reset_error", {7'd0, rx_if.rx_error}, 8'h00);
        rst = 1'b0;
        wait_ticks(20);

        // Two back-to-back good frames.
        expect_good(8'h41);
        send_byte(8'h41, 1'b1);
        expect_good(8'h42);
        send_byte(8'h42, 1'b1);
        wait_ticks(4);
        check_val("data_after_42", rx_if.rx_data, 8'h42);

        // Framing error, then a long break, then recovery.
        sb_q.push_back('{is_err: 1'b1, data: 8'h42});
        send_byte(8'hA5, 1'b0);
        wait_ticks(40);
        check_val("data_after_break", rx_if.rx_data, 8'h42);
        rx_serial = 1'b1;
        wait_ticks(20);
        expect_good(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_ticks(10);

        // Four-tick low glitch must be rejected as a false start.
        rx_serial = 1'b0;
        wait_ticks(4);
        rx_serial = 1'b1;
        wait_ticks(20);
        check_val("state_after_glitch", {5'd0, dut.r_state}, {5'd0, IDLE});
        expect_good(8'h55);
        send_byte(8'h55, 1'b1);
        wait_ticks(10);

        // Reset in the middle of data bit 3 of 0x96.
        partial   = 8'h96;
        rx_serial = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_serial = partial[i];
            wait_ticks(16);
        end
        rx_serial = partial[3];
        wait_ticks(8);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        check_val("midreset_data",  rx_if.rx_data, 8'h00);
        check_val("midreset_ready", {7'd0, rx_if.rx_ready}, 8'h00);
        check_val("midreset_error", {7'd0, rx_if.rx_error}, 8'h00);
        check_val("midreset_state", {5'd0, dut.r_state}, {5'd0, IDLE});
        rst       = 1'b0;
        last_good = 8'h00;
        wait_ticks(20);
        expect_good(8'hFF);
        send_byte(8'hFF, 1'b1);
        expect_good(8'h00);
        send_byte(8'h00, 1'b1);
        wait_ticks(10);

        // Pulse-style baud reference.
        pulse_mode = 1'b1;
        wait_ticks(20);
        expect_good(8'h81);
        send_byte(8'h81, 1'b1);
        wait_ticks(20);
        check_val("data_after_81", rx_if.rx_data, 8'h81);

        // Bounded drain: every expected strobe must have been seen.
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected strobes never seen, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_core
`default_nettype wire
